// File: rtl/maze_path_reader.sv
// Drains the solver's DFS direction stack (last move first), buffers it, then
// replays the moves forward from the start cell as (dir, x, y) beats on valid/ready.
module maze_path_reader #(
    parameter int DEPTH   = 256,
    parameter int COORD_W = 4,
    parameter int START_X = 0,
    parameter int START_Y = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stk_empty,
    input  logic [1:0]         stk_dout,
    output logic               stk_pop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_dir,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [COORD_W-1:0] SX = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] SY = COORD_W'(START_Y);

    typedef enum logic [2:0] {S_IDLE, S_POP, S_CAP, S_PLAY, S_DONE} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [AW-1:0]        rd_q;
    logic [COORD_W-1:0]   pos_x_q, pos_y_q;
    logic                 valid_q, last_q, ovf_q;
    logic [1:0]           dir_q;
    logic [COORD_W-1:0]   x_q, y_q;
    logic [1:0]           buf_q [DEPTH];
    logic [AW-1:0]        rd_nxt;

    assign rd_nxt = rd_q - AW'(1);

    // Wrap-around move: coordinates are modulo 2^COORD_W, no edge checking.
    function automatic logic [2*COORD_W-1:0] step(input logic [1:0] dir,
                                                  input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
        logic [COORD_W-1:0] nx, ny;
        nx = x;
        ny = y;
        case (dir)
            2'b00: ny = y - COORD_W'(1);
            2'b01: nx = x + COORD_W'(1);
            2'b10: nx = x - COORD_W'(1);
            default: ny = y + COORD_W'(1);
        endcase
        return {nx, ny};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            pos_x_q <= SX;
            pos_y_q <= SY;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dir_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    cnt_q   <= '0;
                    ovf_q   <= 1'b0;
                    pos_x_q <= SX;
                    pos_y_q <= SY;
                    state_q <= stk_empty ? S_DONE : S_POP;
                end
                S_POP: state_q <= S_CAP;
                S_CAP: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (stk_empty) begin
                        // Entry just captured is the first move; present it directly.
                        state_q    <= S_PLAY;
                        rd_q       <= cnt_q[AW-1:0];
                        valid_q    <= 1'b1;
                        dir_q      <= stk_dout;
                        {x_q, y_q} <= step(stk_dout, pos_x_q, pos_y_q);
                        last_q     <= (cnt_q == '0);
                    end else if ((cnt_q + CW'(1)) == CW'(DEPTH)) begin
                        ovf_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_POP;
                    end
                end
                S_PLAY: if (out_ready) begin
                    pos_x_q <= x_q;
                    pos_y_q <= y_q;
                    if (rd_q == '0) begin
                        state_q <= S_DONE;
                        valid_q <= 1'b0;
                        dir_q   <= '0;
                        x_q     <= '0;
                        y_q     <= '0;
                        last_q  <= 1'b0;
                    end else begin
                        rd_q       <= rd_nxt;
                        dir_q      <= buf_q[rd_nxt];
                        {x_q, y_q} <= step(buf_q[rd_nxt], x_q, y_q);
                        last_q     <= (rd_nxt == '0);
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_CAP)
            buf_q[cnt_q[AW-1:0]] <= stk_dout;
    end

    assign stk_pop   = (state_q == S_POP);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign overflow  = ovf_q;
    assign out_valid = valid_q;
    assign out_dir   = dir_q;
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_last  = last_q;
endmodule

// File: tb/tb_maze_path_reader.sv
// Directed bench: a small LIFO stack model feeds the reader; beats are checked
// against hand-derived forward replays of the pushed moves.
module tb_maze_path_reader;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stk_empty;
    logic [1:0]    stk_dout;
    logic          stk_pop;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_dir;
    logic [CW-1:0] out_x, out_y;
    logic          out_last, busy, done, overflow;

    maze_path_reader #(.DEPTH(4), .COORD_W(CW), .START_X(0), .START_Y(0)) dut (
        .clk(clk), .rst(rst), .start(start), .stk_empty(stk_empty), .stk_dout(stk_dout),
        .stk_pop(stk_pop), .out_valid(out_valid), .out_ready(out_ready), .out_dir(out_dir),
        .out_x(out_x), .out_y(out_y), .out_last(out_last), .busy(busy), .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Stack model: pop result and post-pop empty flag appear the cycle after stk_pop.
    logic [1:0] stk_mem [8];
    int         sp = 0, ld_n = 0, pop_cnt = 0, beat_cnt = 0;
    logic       ld_en = 1'b0;

    assign stk_empty = (sp == 0);

    always @(posedge clk) begin
        if (ld_en) begin
            sp       <= ld_n;
            pop_cnt  <= 0;
            beat_cnt <= 0;
            stk_dout <= 2'b00;
        end else begin
            if (stk_pop && sp > 0) begin
                stk_dout <= stk_mem[sp-1];
                sp       <= sp - 1;
            end
            if (stk_pop) pop_cnt <= pop_cnt + 1;
            if (out_valid && out_ready) beat_cnt <= beat_cnt + 1;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_stack(input int n, input logic [1:0] d0, input logic [1:0] d1,
                              input logic [1:0] d2, input logic [1:0] d3, input logic [1:0] d4);
        stk_mem[0] = d0; stk_mem[1] = d1; stk_mem[2] = d2; stk_mem[3] = d3; stk_mem[4] = d4;
        ld_n  = n;
        ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for a beat, checks it, and steps one cycle if it will be accepted.
    task automatic expect_beat(input string tag, input logic [1:0] d, input int x, input int y,
                               input logic l);
        int k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_vld"},  out_valid, 1);
        chk({tag, "_dir"},  out_dir, d);
        chk({tag, "_x"},    out_x, x);
        chk({tag, "_y"},    out_y, y);
        chk({tag, "_last"}, out_last, l);
        if (out_ready) @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_dvld"}, out_valid, 0);
        chk({tag, "_ddir"}, {out_dir, out_x, out_y, out_last}, 0);
        @(negedge clk);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int lat;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_outs", {stk_pop, out_valid, out_dir, out_x, out_y, out_last, busy, done, overflow}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: empty stack
        pulse_start();
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 1);
        chk("t1_pop",  stk_pop, 0);
        chk("t1_vld",  out_valid, 0);
        @(negedge clk);
        chk("t1_done2", done, 0);
        chk("t1_busy2", busy, 0);
        chk("t1_pops",  pop_cnt, 0);

        // 2: pushed 01,01,11
        load_stack(3, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t2_pop1", stk_pop, 1);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("t2_lat", lat, 7);
        expect_beat("t2_b1", 2'b01, 1, 0, 1'b0);
        expect_beat("t2_b2", 2'b01, 2, 0, 1'b0);
        expect_beat("t2_b3", 2'b11, 2, 1, 1'b1);
        wait_done("t2");
        chk("t2_pops",  pop_cnt, 3);
        chk("t2_beats", beat_cnt, 3);

        // 3: backpressure on beat 2
        load_stack(3, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00);
        pulse_start();
        expect_beat("t3_b1", 2'b01, 1, 0, 1'b0);
        out_ready = 1'b0;
        expect_beat("t3_b2", 2'b01, 2, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold", {out_valid, out_dir, out_x, out_y, out_last}, {1'b1, 2'b01, 4'd2, 4'd0, 1'b0});
        end
        out_ready = 1'b1;
        expect_beat("t3_b2r", 2'b01, 2, 0, 1'b0);
        expect_beat("t3_b3",  2'b11, 2, 1, 1'b1);
        wait_done("t3");
        chk("t3_beats", beat_cnt, 3);

        // 4: single left move wraps x
        load_stack(1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        pulse_start();
        expect_beat("t4_b1", 2'b10, 15, 0, 1'b1);
        wait_done("t4");
        chk("t4_pops", pop_cnt, 1);

        // 5: overflow with DEPTH=4
        load_stack(5, 2'b01, 2'b11, 2'b01, 2'b11, 2'b01);
        pulse_start();
        wait_done("t5");
        chk("t5_pops",  pop_cnt, 4);
        chk("t5_ovf",   overflow, 1);
        chk("t5_beats", beat_cnt, 0);
        load_stack(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        chk("t5_ovf_hold", overflow, 1);
        pulse_start();
        chk("t5_ovf_clr", overflow, 0);
        expect_beat("t5_b1", 2'b01, 1, 0, 1'b1);
        wait_done("t5b");

        // 6: reset mid-play, then clean replay
        load_stack(3, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00);
        pulse_start();
        expect_beat("t6_b1", 2'b01, 1, 0, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_rst_outs", {stk_pop, out_valid, out_dir, out_x, out_y, out_last, busy, done, overflow}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_idle",  {busy, stk_pop, out_valid}, 0);
        chk("t6_beats", beat_cnt, 1);
        load_stack(3, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00);
        pulse_start();
        expect_beat("t6_r1", 2'b01, 1, 0, 1'b0);
        expect_beat("t6_r2", 2'b01, 2, 0, 1'b0);
        expect_beat("t6_r3", 2'b11, 2, 1, 1'b1);
        wait_done("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
